// File: rtl/udp_echo_responder_pkg.sv
// Shared types and constants for the UDP echo responder.
package udp_echo_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX_PAYLOAD,
    ST_TX_HEADER,
    ST_TX_PAYLOAD
  } echo_state_e;

  localparam logic [15:0] UDP_HDR_LEN = 16'd8;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/udp_echo_responder_if.sv
// Header and byte-stream interfaces used by the UDP echo responder.
interface udp_rx_header_if;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [31:0] ip_source_ip;
  logic [15:0] source_port;
  logic [15:0] dest_port;

  modport sink   (input hdr_valid, ip_source_ip, source_port, dest_port, output hdr_ready);
  modport source (output hdr_valid, ip_source_ip, source_port, dest_port, input hdr_ready);
endinterface

interface udp_tx_header_if;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [31:0] ip_dest_ip;
  logic [15:0] dest_port;
  logic [15:0] source_port;
  logic [15:0] length;
  logic [7:0]  ip_ttl;
  logic [5:0]  ip_dscp;
  logic [1:0]  ip_ecn;
  logic [15:0] checksum;

  modport source (output hdr_valid, ip_dest_ip, dest_port, source_port, length, ip_ttl,
                  ip_dscp, ip_ecn, checksum, input hdr_ready);
  modport sink   (input hdr_valid, ip_dest_ip, dest_port, source_port, length, ip_ttl,
                  ip_dscp, ip_ecn, checksum, output hdr_ready);
endinterface

interface axis_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tready;
  logic                tlast;
  logic                tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/udp_echo_responder_simple_dp_ram.sv
// Payload buffer: one write port, one read port with a registered output.
module simple_dp_ram #(
  parameter int DEPTH  = 2048,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data <= mem_q[rd_addr];
  end

endmodule

// File: rtl/udp_echo_responder.sv
// Store-and-forward UDP echo: buffers one datagram, then replies with ports/addresses swapped.
//   state         | meaning
//   ST_IDLE       | waiting for an rx header
//   ST_RX_PAYLOAD | storing payload bytes until tlast
//   ST_TX_HEADER  | presenting the reply header
//   ST_TX_PAYLOAD | streaming the buffered bytes back out
module udp_echo_responder
  import udp_echo_responder_pkg::*;
#(
  parameter int          BUFFER_DEPTH = 2048,
  parameter logic [7:0]  IP_TTL       = 8'd64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  udp_rx_header_if.sink          udp_rx_header_if_sink,
  axis_if.slave                  udp_rx_payload_if_sink,
  udp_tx_header_if.source        udp_tx_header_if_source,
  axis_if.master                 udp_tx_payload_if_source,
  output logic [31:0]            echo_count,
  output logic [15:0]            drop_count
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUFFER_DEPTH);

  echo_state_e   state_q, state_d;
  logic [CW-1:0] byte_count_q, byte_count_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   src_ip_q, src_ip_d;
  logic [15:0]   src_port_q, src_port_d;
  logic [15:0]   dst_port_q, dst_port_d;
  logic [31:0]   echo_count_q, echo_count_d;
  logic [15:0]   drop_count_q, drop_count_d;

  logic          wr_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          last_beat;

  simple_dp_ram #(.DEPTH(BUFFER_DEPTH), .WIDTH(8), .ADDR_W(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (byte_count_q[AW-1:0]),
    .wr_data (udp_rx_payload_if_sink.tdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign last_beat = (rd_idx_q == byte_count_q - CW'(1));

  always_comb begin
    state_d      = state_q;
    byte_count_d = byte_count_q;
    rd_idx_d     = rd_idx_q;
    overflow_d   = overflow_q;
    src_ip_d     = src_ip_q;
    src_port_d   = src_port_q;
    dst_port_d   = dst_port_q;
    echo_count_d = echo_count_q;
    drop_count_d = drop_count_q;
    wr_en        = 1'b0;

    udp_rx_header_if_sink.hdr_ready  = 1'b0;
    udp_rx_payload_if_sink.tready    = 1'b0;

    udp_tx_header_if_source.hdr_valid   = 1'b0;
    udp_tx_header_if_source.ip_dest_ip  = src_ip_q;
    udp_tx_header_if_source.dest_port   = src_port_q;
    udp_tx_header_if_source.source_port = dst_port_q;
    udp_tx_header_if_source.length      = UDP_HDR_LEN + 16'(byte_count_q);
    udp_tx_header_if_source.ip_ttl      = IP_TTL;
    udp_tx_header_if_source.ip_dscp     = 6'd0;
    udp_tx_header_if_source.ip_ecn      = 2'd0;
    udp_tx_header_if_source.checksum    = 16'd0;

    udp_tx_payload_if_source.tvalid = 1'b0;
    udp_tx_payload_if_source.tdata  = rd_data;
    udp_tx_payload_if_source.tlast  = 1'b0;
    udp_tx_payload_if_source.tkeep  = 1'b1;
    udp_tx_payload_if_source.tuser  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Gated by reset so the header port stays quiet while reset is held.
        udp_rx_header_if_sink.hdr_ready = reset_n;
        if (udp_rx_header_if_sink.hdr_valid) begin
          src_ip_d     = udp_rx_header_if_sink.ip_source_ip;
          src_port_d   = udp_rx_header_if_sink.source_port;
          dst_port_d   = udp_rx_header_if_sink.dest_port;
          byte_count_d = '0;
          rd_idx_d     = '0;
          overflow_d   = 1'b0;
          state_d      = ST_RX_PAYLOAD;
        end
      end
      ST_RX_PAYLOAD: begin
        udp_rx_payload_if_sink.tready = 1'b1;
        if (udp_rx_payload_if_sink.tvalid) begin
          if (byte_count_q < DEPTH_C) begin
            wr_en        = 1'b1;
            byte_count_d = byte_count_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
          if (udp_rx_payload_if_sink.tlast) begin
            if (udp_rx_payload_if_sink.tuser || overflow_d) begin
              drop_count_d = sat_inc16(drop_count_q);
              state_d      = ST_IDLE;
            end else begin
              state_d = ST_TX_HEADER;
            end
          end
        end
      end
      ST_TX_HEADER: begin
        udp_tx_header_if_source.hdr_valid = 1'b1;
        if (udp_tx_header_if_source.hdr_ready) state_d = ST_TX_PAYLOAD;
      end
      ST_TX_PAYLOAD: begin
        udp_tx_payload_if_source.tvalid = 1'b1;
        udp_tx_payload_if_source.tlast  = last_beat;
        if (udp_tx_payload_if_source.tready) begin
          if (last_beat) begin
            echo_count_d = echo_count_q + 32'd1;
            state_d      = ST_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reading the next index a cycle early keeps rd_data aligned with rd_idx_q.
    rd_addr = rd_idx_d[AW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      byte_count_q <= '0;
      rd_idx_q     <= '0;
      overflow_q   <= 1'b0;
      src_ip_q     <= '0;
      src_port_q   <= '0;
      dst_port_q   <= '0;
      echo_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_count_q <= byte_count_d;
      rd_idx_q     <= rd_idx_d;
      overflow_q   <= overflow_d;
      src_ip_q     <= src_ip_d;
      src_port_q   <= src_port_d;
      dst_port_q   <= dst_port_d;
      echo_count_q <= echo_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign echo_count = echo_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: doc/udp_echo_responder.md
UDP_ECHO_RESPONDER -- requirements
Module: udp_echo_responder

Interface
REQ-001 SHALL have parameter BUFFER_DEPTH, default 2048, meaning payload buffer size in bytes (power of two, at least 64).
REQ-002 SHALL have parameter IP_TTL, default 8'd64, meaning the TTL placed in every reply header.
REQ-003 SHALL have port clk, input, 1, meaning the single clock domain for all logic.
REQ-004 SHALL have port reset_n, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-005 SHALL have port udp_rx_header_if_sink, UDP_RX_HEADER_IF.Sink, meaning the incoming datagram header.
REQ-006 SHALL have port udp_rx_payload_if_sink, AXIS_IF.Slave (8-bit), meaning the incoming payload; tuser=1 on the tlast beat marks a bad frame.
REQ-007 SHALL have port udp_tx_header_if_source, UDP_TX_HEADER_IF.Source, meaning the reply header.
REQ-008 SHALL have port udp_tx_payload_if_source, AXIS_IF.Master (8-bit), meaning the reply payload.
REQ-009 SHALL have port echo_count, output, 32, meaning the number of replies completed, wrapping at 2^32.
REQ-010 SHALL have port drop_count, output, 16, meaning the number of datagrams discarded, saturating at 16'hFFFF.

Function
REQ-011 SHALL be a store-and-forward responder with four states: IDLE -> RX_PAYLOAD -> TX_HEADER -> TX_PAYLOAD -> IDLE.
REQ-012 SHALL drive rx hdr_ready=1 only in IDLE; on the rx header handshake it SHALL latch ip_source_ip, source_port and dest_port, then enter RX_PAYLOAD on the next cycle.
REQ-013 SHALL drive rx tready=1 only in RX_PAYLOAD, writing each accepted byte to the buffer at byte_count and incrementing byte_count.
REQ-014 SHALL not write bytes beyond BUFFER_DEPTH; instead it sets an overflow flag and keeps accepting until tlast.
REQ-015 On the tlast handshake, SHALL go to IDLE and increment drop_count if tuser=1 or overflow is set; otherwise it SHALL go to TX_HEADER.
REQ-016 In TX_HEADER, SHALL assert tx hdr_valid, held with all fields stable until hdr_ready, with these fields:
  - ip_dest_ip = latched ip_source_ip
  - dest_port = latched source_port
  - source_port = latched dest_port
  - length = byte_count+8
  - ip_ttl = IP_TTL
  - ip_dscp = 0, ip_ecn = 0, checksum = 0
REQ-017 SHALL assert tx hdr_valid on the cycle after the rx tlast handshake.
REQ-018 SHALL present the first tx payload tvalid within 2 cycles after the tx header handshake, accounting for the 1-cycle RAM read latency with a prefetch or skid register.
REQ-019 SHALL keep tx tdata, tvalid and tlast stable while tvalid=1 and tready=0.
REQ-020 SHALL sustain one byte per cycle while tready=1.
REQ-021 SHALL drive tx tlast on byte byte_count-1, tuser=0 and tkeep=1; on that handshake it SHALL increment echo_count and return to IDLE.
REQ-022 SHALL handle a 1-byte datagram (tlast on the first beat) as length=9 with a single tx beat carrying tlast.
REQ-023 SHALL handle a datagram of exactly BUFFER_DEPTH bytes as no overflow, and echo it.
REQ-024 SHALL not accept any new rx header until the current reply completes, so no two datagrams are ever interleaved.

Reset
REQ-025 While reset_n=0 (asynchronous assert, synchronous release), SHALL force state=IDLE, every valid/ready output=0, byte_count=0, overflow=0, echo_count=0 and drop_count=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without counting it; after release, rx hdr_ready=1 on the first cycle.

Structure
REQ-027 SHALL place the state enum and the UDP header length constant (16'd8) in the shared udp package.
REQ-028 SHALL use one sub-module, simple_dp_ram (1 write port, 1 registered read port, BUFFER_DEPTH x 8).

Verification
REQ-029 Bench SHALL cover: rx header from 10.0.0.2:5000 to 10.0.0.1:7, 4-byte payload DE AD BE EF -> tx header to 10.0.0.2:5000, source_port 7, length 12, ttl 64; payload DE AD BE EF with tlast on EF; echo_count=1.
REQ-030 Bench SHALL cover: same datagram with tuser=1 on the last beat -> no tx header; drop_count=1; rx hdr_ready=1 again within 2 cycles.
REQ-031 Bench SHALL cover: 2049-byte datagram at BUFFER_DEPTH=2048 -> dropped, drop_count+1; a following 2048-byte datagram is echoed with length 2056.
REQ-032 Bench SHALL cover: tx tready toggled randomly at 50% on a 100-byte echo -> the output byte sequence is identical to the input and no data changes while stalled.
REQ-033 Bench SHALL cover: 1-byte datagram 0x5A -> length 9, single tx beat 0x5A with tlast=1.
REQ-034 Bench SHALL cover: reset_n pulsed low during TX_PAYLOAD -> tvalid=0 immediately; counters=0; the next datagram is echoed correctly.
